// File: rtl/queue_drain_reader_pkg.sv
// Shared types and default sizing for the queue drain reader.
package queue_drain_reader_pkg;

    localparam int unsigned DEFAULT_DATA_W = 64;
    localparam int unsigned DEFAULT_DEPTH  = 5;
    localparam int unsigned CNT_W          = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AGE,
        ST_DRAIN,
        ST_REPORT
    } state_e;

endpackage

// File: rtl/queue_drain_reader_occ_tracker.sv
// Shadow occupancy counter of the attached queue plus the sticky protocol-error flag.
module occ_tracker
    import queue_drain_reader_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             push_valid_i,
    input  logic             pop_valid_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] occ_o,
    output logic [CNT_W-1:0] occ_next_c_o,
    output logic             err_o
);

    logic [CNT_W-1:0] occ_q, occ_d;
    logic             err_q, err_d;

    // Saturating occupancy update; overflow, underflow and an unanswered pop all latch err.
    always_comb begin
        occ_d = occ_q;
        err_d = err_q;
        if (en_i) begin
            if (push_valid_i && !pop_valid_i && (occ_q != CNT_W'(DEPTH))) begin
                occ_d = occ_q + CNT_W'(1);
            end else if (pop_valid_i && !push_valid_i && (occ_q != '0)) begin
                occ_d = occ_q - CNT_W'(1);
            end
            if ((push_valid_i && !pop_valid_i && (occ_q == CNT_W'(DEPTH))) ||
                (pop_valid_i && (occ_q == '0)) ||
                (pop_i && !pop_valid_i && (occ_q != '0))) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q <= '0;
            err_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            err_q <= err_d;
        end
    end

    assign occ_o        = occ_q;
    assign occ_next_c_o = occ_d;
    assign err_o        = err_q;

endmodule

// File: rtl/queue_drain_reader.sv
// Drains a time-tracking queue on timeout or high water and reports sum/count/max-wait.
// Optional max_waited tracking is enabled by defining READER_MAXWAIT_EN.
module queue_drain_reader
    import queue_drain_reader_pkg::*;
#(
    parameter int unsigned DATA_W     = DEFAULT_DATA_W,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned TIMEOUT    = 8,
    parameter int unsigned HIGH_WATER = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     push_valid,
    input  logic                     pop_valid,
    input  logic signed [DATA_W-1:0] out,
    input  logic signed [DATA_W-1:0] waited,
    output logic                     pop,
    output logic signed [DATA_W-1:0] sum,
    output logic [CNT_W-1:0]         n,
    output logic signed [DATA_W-1:0] max_waited,
    output logic                     report,
    output logic [CNT_W-1:0]         occ,
    output logic                     err
);

    localparam int unsigned AGE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e                    state_q;
    logic [AGE_W-1:0]          age_q;
    logic signed [DATA_W-1:0]  sum_q;
    logic signed [DATA_W-1:0]  max_q;
    logic [CNT_W-1:0]          n_q;
    logic                      pop_q;
    logic                      report_q;

    logic [CNT_W-1:0]          occ_next_c;
    logic [CNT_W-1:0]          n_inc_c;
    logic                      age_done_c;
    logic                      hw_hit_c;
    logic                      drain_end_c;

    occ_tracker #(
        .DEPTH(DEPTH)
    ) u_occ_tracker (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .push_valid_i (push_valid),
        .pop_valid_i  (pop_valid),
        .pop_i        (pop),
        .occ_o        (occ),
        .occ_next_c_o (occ_next_c),
        .err_o        (err)
    );

    assign n_inc_c     = n_q + CNT_W'(1);
    assign age_done_c  = (age_q == AGE_W'(TIMEOUT - 1));
    assign hw_hit_c    = (occ_next_c >= CNT_W'(HIGH_WATER));
    assign drain_end_c = !pop_valid || (occ_next_c == '0) || (n_inc_c == CNT_W'(DEPTH));

    // Drain sequencer; statistics are cleared on DRAIN entry and held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            age_q    <= '0;
            sum_q    <= '0;
            max_q    <= '0;
            n_q      <= '0;
            pop_q    <= 1'b0;
            report_q <= 1'b0;
        end else if (en) begin
            report_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    age_q <= '0;
                    if (push_valid) begin
                        state_q <= ST_AGE;
                    end
                end
                ST_AGE: begin
                    age_q <= age_q + AGE_W'(1);
                    if (age_done_c || hw_hit_c) begin
                        state_q <= ST_DRAIN;
                        age_q   <= '0;
                        sum_q   <= '0;
                        max_q   <= '0;
                        n_q     <= '0;
                        pop_q   <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (pop_valid) begin
                        sum_q <= sum_q + out;
                        n_q   <= n_inc_c;
`ifdef READER_MAXWAIT_EN
                        if (waited > max_q) begin
                            max_q <= waited;
                        end
`endif
                    end
                    if (drain_end_c) begin
                        state_q  <= ST_REPORT;
                        pop_q    <= 1'b0;
                        report_q <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    age_q   <= '0;
                    state_q <= (occ_next_c != '0) ? ST_AGE : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifndef READER_MAXWAIT_EN
    logic unused_waited;
    assign unused_waited = ^waited;
`endif

    // pop drops immediately while the clock enable is low.
    assign pop        = pop_q & en;
    assign sum        = sum_q;
    assign n          = n_q;
    assign max_waited = max_q;
    assign report     = report_q;

endmodule

// File: tb/tb_queue_drain_reader.sv
// Directed self-checking bench for queue_drain_reader; the bench plays the attached queue.
module tb_queue_drain_reader;

    logic               clk;
    logic               rst;
    logic               en;
    logic               push_valid;
    logic               pop_valid;
    logic signed [63:0] out;
    logic signed [63:0] waited;
    logic               pop;
    logic signed [63:0] sum;
    logic [2:0]         n;
    logic signed [63:0] max_waited;
    logic               report;
    logic [2:0]         occ;
    logic               err;

    int checks = 0;
    int errors = 0;

    logic signed [63:0] qd[$];
    logic signed [63:0] qw[$];

    queue_drain_reader dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .push_valid (push_valid),
        .pop_valid  (pop_valid),
        .out        (out),
        .waited     (waited),
        .pop        (pop),
        .sum        (sum),
        .n          (n),
        .max_waited (max_waited),
        .report     (report),
        .occ        (occ),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    // One clock cycle, entered and left at a falling edge; answers pop from the queue model.
    task automatic tick(input logic psh, input logic signed [63:0] d,
                        input logic signed [63:0] w, input logic block_pv);
        logic pv;
        #1;
        pv = pop && (qd.size() > 0) && !block_pv;
        pop_valid = pv;
        if (pv) begin
            out    = qd.pop_front();
            waited = qw.pop_front();
        end else begin
            out    = '0;
            waited = '0;
        end
        push_valid = psh;
        if (psh) begin
            qd.push_back(d);
            qw.push_back(w);
        end
        @(posedge clk);
        if (rst) begin
            qd.delete();
            qw.delete();
        end
        @(negedge clk);
    endtask

    task automatic idle();
        tick(1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        idle();
        checks++; if (pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %0d want 0", pop); end
        checks++; if (report !== 1'b0) begin errors++; $display("FAIL reset_report: got %0d want 0", report); end
        checks++; if (sum !== 64'sd0) begin errors++; $display("FAIL reset_sum: got %0d want 0", sum); end
        checks++; if (n !== 3'd0) begin errors++; $display("FAIL reset_n: got %0d want 0", n); end
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occ); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0d want 0", err); end
        checks++; if (max_waited !== 64'sd0) begin errors++; $display("FAIL reset_max: got %0d want 0", max_waited); end
        rst = 1'b0;
    endtask

    task automatic test_timeout_drain();
        for (int i = 0; i < 12; i++) begin
            tick((i % 4) == 0, 64'(i / 4 + 1), 64'sd0, 1'b0);
            if (i == 7) begin
                checks++; if (pop !== 1'b0) begin errors++; $display("FAIL timeout_early_pop: got %0d want 0", pop); end
            end
            if (i == 8) begin
                checks++; if (pop !== 1'b1) begin errors++; $display("FAIL timeout_pop: got %0d want 1", pop); end
            end
        end
        checks++; if (report !== 1'b1) begin errors++; $display("FAIL timeout_report: got %0d want 1", report); end
        checks++; if (sum !== 64'sd6) begin errors++; $display("FAIL timeout_sum: got %0d want 6", sum); end
        checks++; if (n !== 3'd3) begin errors++; $display("FAIL timeout_n: got %0d want 3", n); end
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL timeout_occ: got %0d want 0", occ); end
        idle();
        checks++; if (report !== 1'b0) begin errors++; $display("FAIL timeout_report_pulse: got %0d want 0", report); end
        checks++; if (sum !== 64'sd6) begin errors++; $display("FAIL timeout_sum_hold: got %0d want 6", sum); end
    endtask

    task automatic test_high_water();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 64'(i + 4), 64'sd0, 1'b0);
            if (i == 2) begin
                checks++; if (pop !== 1'b0) begin errors++; $display("FAIL hw_early_pop: got %0d want 0", pop); end
            end
        end
        checks++; if (pop !== 1'b1) begin errors++; $display("FAIL hw_pop: got %0d want 1", pop); end
        for (int i = 0; i < 4; i++) idle();
        checks++; if (report !== 1'b1) begin errors++; $display("FAIL hw_report: got %0d want 1", report); end
        checks++; if (sum !== 64'sd22) begin errors++; $display("FAIL hw_sum: got %0d want 22", sum); end
        checks++; if (n !== 3'd4) begin errors++; $display("FAIL hw_n: got %0d want 4", n); end
        idle();
    endtask

    task automatic test_enable_hold();
        for (int i = 0; i < 4; i++) tick(1'b1, 64'(i + 1), 64'sd0, 1'b0);
        en = 1'b0;
        idle();
        idle();
        checks++; if (pop !== 1'b0) begin errors++; $display("FAIL en_pop: got %0d want 0", pop); end
        checks++; if (occ !== 3'd4) begin errors++; $display("FAIL en_occ: got %0d want 4", occ); end
        checks++; if (n !== 3'd0) begin errors++; $display("FAIL en_n: got %0d want 0", n); end
        en = 1'b1;
        #1;
        checks++; if (pop !== 1'b1) begin errors++; $display("FAIL en_pop_resume: got %0d want 1", pop); end
        for (int i = 0; i < 4; i++) idle();
        checks++; if (report !== 1'b1) begin errors++; $display("FAIL en_report: got %0d want 1", report); end
        checks++; if (sum !== 64'sd10) begin errors++; $display("FAIL en_sum: got %0d want 10", sum); end
        idle();
    endtask

    task automatic test_push_during_drain();
        int cnt;
        for (int i = 0; i < 4; i++) tick(1'b1, 64'(10 * (i + 1)), 64'sd0, 1'b0);
        tick(1'b1, 64'sd50, 64'sd0, 1'b0);
        checks++; if (occ !== 3'd4) begin errors++; $display("FAIL pd_occ: got %0d want 4", occ); end
        tick(1'b1, 64'sd60, 64'sd0, 1'b0);
        checks++; if (n !== 3'd2) begin errors++; $display("FAIL pd_n_mid: got %0d want 2", n); end
        for (int i = 0; i < 3; i++) idle();
        checks++; if (report !== 1'b1) begin errors++; $display("FAIL pd_report: got %0d want 1", report); end
        checks++; if (n !== 3'd5) begin errors++; $display("FAIL pd_n_cap: got %0d want 5", n); end
        checks++; if (sum !== 64'sd150) begin errors++; $display("FAIL pd_sum: got %0d want 150", sum); end
        checks++; if (occ !== 3'd1) begin errors++; $display("FAIL pd_occ_left: got %0d want 1", occ); end
        idle();
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            idle();
            cnt++;
            if (report) break;
        end
        checks++; if (cnt !== 9) begin errors++; $display("FAIL pd_second_drain_cycles: got %0d want 9", cnt); end
        checks++; if (sum !== 64'sd60) begin errors++; $display("FAIL pd_second_sum: got %0d want 60", sum); end
        checks++; if (n !== 3'd1) begin errors++; $display("FAIL pd_second_n: got %0d want 1", n); end
        idle();
    endtask

    task automatic test_max_waited();
        int cnt;
        logic signed [63:0] exp_max;
`ifdef READER_MAXWAIT_EN
        exp_max = 64'sd9;
`else
        exp_max = 64'sd0;
`endif
        tick(1'b1, 64'sd100, 64'sd3, 1'b0);
        tick(1'b1, -64'sd50, -64'sd1, 1'b0);
        tick(1'b1, 64'sd7, 64'sd9, 1'b0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            idle();
            cnt++;
            if (report) break;
        end
        checks++; if (cnt !== 9) begin errors++; $display("FAIL mw_cycles: got %0d want 9", cnt); end
        checks++; if (sum !== 64'sd57) begin errors++; $display("FAIL mw_sum: got %0d want 57", sum); end
        checks++; if (max_waited !== exp_max) begin errors++; $display("FAIL mw_max: got %0d want %0d", max_waited, exp_max); end
        idle();
    endtask

    task automatic test_pop_missing_err();
        tick(1'b1, 64'sd11, 64'sd0, 1'b0);
        tick(1'b1, 64'sd22, 64'sd0, 1'b0);
        for (int i = 0; i < 7; i++) idle();
        checks++; if (pop !== 1'b1) begin errors++; $display("FAIL pe_pop: got %0d want 1", pop); end
        tick(1'b0, '0, '0, 1'b1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL pe_err: got %0d want 1", err); end
        checks++; if (report !== 1'b1) begin errors++; $display("FAIL pe_report: got %0d want 1", report); end
        checks++; if (n !== 3'd0) begin errors++; $display("FAIL pe_n: got %0d want 0", n); end
        checks++; if (occ !== 3'd2) begin errors++; $display("FAIL pe_occ: got %0d want 2", occ); end
        for (int i = 0; i < 3; i++) idle();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL pe_err_sticky: got %0d want 1", err); end
        rst = 1'b1;
        idle();
        rst = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL pe_err_clear: got %0d want 0", err); end
    endtask

    task automatic test_reset_mid_drain();
        logic seen;
        for (int i = 0; i < 4; i++) tick(1'b1, 64'(i + 1), 64'sd5, 1'b0);
        idle();
        checks++; if (n !== 3'd1) begin errors++; $display("FAIL rd_n_before: got %0d want 1", n); end
        rst = 1'b1;
        idle();
        rst = 1'b0;
        checks++; if (pop !== 1'b0) begin errors++; $display("FAIL rd_pop: got %0d want 0", pop); end
        checks++; if (report !== 1'b0) begin errors++; $display("FAIL rd_report: got %0d want 0", report); end
        checks++; if (sum !== 64'sd0) begin errors++; $display("FAIL rd_sum: got %0d want 0", sum); end
        checks++; if (n !== 3'd0) begin errors++; $display("FAIL rd_n: got %0d want 0", n); end
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL rd_occ: got %0d want 0", occ); end
        checks++; if (max_waited !== 64'sd0) begin errors++; $display("FAIL rd_max: got %0d want 0", max_waited); end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            if (report || pop) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rd_no_report: got %0d want 0", seen); end
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        push_valid = 1'b0;
        pop_valid  = 1'b0;
        out        = '0;
        waited     = '0;
        @(negedge clk);
        test_reset();
        test_timeout_drain();
        test_high_water();
        test_enable_hold();
        test_push_during_drain();
        test_max_waited();
        test_pop_missing_err();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
